imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised successor to the combinational immediate sign-extender.

---
 rtl/imm_gen_pipe.sv | 102 ++++++++++
 tb/tb_imm_gen_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes instr[31:7] per format select and returns the
// XLEN-wide immediate one cycle later through a valid/ready output stage with a skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [24:0]       in_instr,
  input  logic [2:0]        in_immsrc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal,
  output logic              illegal_seen
);

  logic [31:7]      ins;
  logic [31:0]      v;
  logic [XLEN-1:0]  imm_new;
  logic             ill_new;

  logic             or_valid, sk_valid;
  logic [XLEN-1:0]  or_imm, sk_imm;
  logic [TAG_W-1:0] or_tag, sk_tag;
  logic             or_ill, sk_ill;

  logic             in_fire, or_free;

  assign ins = in_instr;

  // v is built so that bit 31 is the fill bit; zero-extended formats keep it 0
  always_comb begin
    v       = '0;
    ill_new = 1'b0;
    case (in_immsrc)
      3'b000: v = {{20{ins[31]}}, ins[31:20]};
      3'b001: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010: v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b100: v = {ins[31:12], 12'b0};
      3'b101: v = {27'b0, ins[19:15]};
      3'b110: v = (XLEN == 64) ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
      default: ill_new = 1'b1;
    endcase
    imm_new       = {XLEN{v[31]}};
    imm_new[31:0] = v;
  end

  assign in_ready = ~sk_valid & ~reset;
  assign in_fire  = in_valid & in_ready;
  assign or_free  = ~or_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid     <= 1'b0;
      or_imm       <= '0;
      or_tag       <= '0;
      or_ill       <= 1'b0;
      sk_valid     <= 1'b0;
      sk_imm       <= '0;
      sk_tag       <= '0;
      sk_ill       <= 1'b0;
      illegal_seen <= 1'b0;
    end else begin
      if (or_free) begin
        if (sk_valid) begin
          // in_ready was low, so no new input can collide with the skid drain
          or_valid <= 1'b1;
          or_imm   <= sk_imm;
          or_tag   <= sk_tag;
          or_ill   <= sk_ill;
          sk_valid <= 1'b0;
        end else begin
          or_valid <= in_fire;
          if (in_fire) begin
            or_imm <= imm_new;
            or_tag <= in_tag;
            or_ill <= ill_new;
          end
        end
      end else if (in_fire) begin
        sk_valid <= 1'b1;
        sk_imm   <= imm_new;
        sk_tag   <= in_tag;
        sk_ill   <= ill_new;
      end
      if (in_fire && ill_new)
        illegal_seen <= 1'b1;
    end
  end

  assign out_valid   = or_valid;
  assign out_imm     = or_imm;
  assign out_tag     = or_tag;
  assign out_illegal = or_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [24:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32, illegal_seen32;
  logic [31:0] out_imm32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, out_illegal64, illegal_seen64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_illegal32), .illegal_seen(illegal_seen32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64), .illegal_seen(illegal_seen64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag);
    in_valid  = 1'b1;
    in_instr  = instr[31:7];
    in_immsrc = src;
    in_tag    = tag;
  endtask

  // single transfer with out_ready=1: checks both widths one cycle later
  task automatic xfer(input string name, input logic [31:0] instr, input logic [2:0] src,
                      input logic [4:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                      input logic eill);
    drive(instr, src, tag);
    step();
    in_valid = 1'b0;
    chk({name, "_valid"}, {63'b0, out_valid32}, 64'd1);
    chk({name, "_imm32"}, {32'b0, out_imm32}, {32'b0, e32});
    chk({name, "_imm64"}, out_imm64, e64);
    chk({name, "_tag"},   {59'b0, out_tag32}, {59'b0, tag});
    chk({name, "_ill"},   {63'b0, out_illegal64}, {63'b0, eill});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_immsrc = '0; in_tag = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_valid", {63'b0, out_valid32}, 64'd0);
    chk("rst_inready", {63'b0, in_ready32}, 64'd0);
    chk("rst_seen", {63'b0, illegal_seen32}, 64'd0);
    chk("rst_imm", out_imm64, 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_inready", {63'b0, in_ready64}, 64'd1);

    xfer("I",  32'hFFF00093, 3'b000, 5'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    xfer("S",  32'hFE112E23, 3'b001, 5'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    xfer("B",  32'hFE000EE3, 3'b010, 5'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    xfer("J",  32'h0080006F, 3'b011, 5'd4, 32'h00000008, 64'h0000000000000008, 1'b0);
    xfer("U",  32'h123450B7, 3'b100, 5'd5, 32'h12345000, 64'h0000000012345000, 1'b0);
    xfer("Z",  32'h000F5073, 3'b101, 5'd6, 32'h0000001E, 64'h000000000000001E, 1'b0);
    xfer("U64", 32'h800000B7, 3'b100, 5'd7, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    xfer("SH", 32'h03F0D093, 3'b110, 5'd8, 32'h0000001F, 64'h000000000000003F, 1'b0);
    step();
    chk("idle_valid", {63'b0, out_valid32}, 64'd0);
    chk("seen_before_ill", {63'b0, illegal_seen32}, 64'd0);

    xfer("ILL", 32'hFFFFFFFF, 3'b111, 5'd9, 32'h00000000, 64'h0, 1'b1);
    chk("ill_seen32", {63'b0, illegal_seen32}, 64'd1);
    chk("ill_out32", {63'b0, out_illegal32}, 64'd1);
    xfer("AFTER", 32'hFFF00093, 3'b000, 5'd10, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    chk("seen_sticky", {63'b0, illegal_seen64}, 64'd1);
    step();

    // backpressure: tag1 stalls in OR, tag2 lands in SK, tag3 is held off
    out_ready = 1'b0;
    drive(32'h00100093, 3'b000, 5'd1);
    step();
    chk("bp_t1_valid", {63'b0, out_valid32}, 64'd1);
    chk("bp_t1_rdy", {63'b0, in_ready32}, 64'd1);
    drive(32'h00200093, 3'b000, 5'd2);
    step();
    chk("bp_sk_rdy", {63'b0, in_ready32}, 64'd0);
    chk("bp_hold_tag", {59'b0, out_tag32}, 64'd1);
    drive(32'h00300093, 3'b000, 5'd3);
    step();
    chk("bp_held_tag", {59'b0, out_tag32}, 64'd1);
    chk("bp_held_imm", {32'b0, out_imm32}, 64'd1);
    chk("bp_held_rdy", {63'b0, in_ready64}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_out2_tag", {59'b0, out_tag32}, 64'd2);
    chk("bp_out2_imm", out_imm64, 64'd2);
    chk("bp_out2_rdy", {63'b0, in_ready32}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out3_tag", {59'b0, out_tag32}, 64'd3);
    chk("bp_out3_valid", {63'b0, out_valid32}, 64'd1);
    step();
    chk("bp_nodup", {63'b0, out_valid32}, 64'd0);

    // reset with both stages full
    out_ready = 1'b0;
    drive(32'hFFFFFFFF, 3'b111, 5'd4);
    step();
    drive(32'h00500093, 3'b000, 5'd5);
    step();
    in_valid = 1'b0;
    chk("full_rdy", {63'b0, in_ready32}, 64'd0);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", {63'b0, out_valid32}, 64'd0);
    chk("mid_rst_seen", {63'b0, illegal_seen32}, 64'd0);
    chk("mid_rst_imm", {32'b0, out_imm32}, 64'd0);
    chk("mid_rst_tag", {59'b0, out_tag32}, 64'd0);
    chk("mid_rst_rdy", {63'b0, in_ready32}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rel_rdy", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("discard_valid", {63'b0, out_valid32}, 64'd0);
    chk("discard_valid64", {63'b0, out_valid64}, 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
